fibo_bcd_display: RTL and testbench



---
 rtl/fibo_pkg.sv | 32 +++
 rtl/fibo_bcd_display_seven_seg.sv | 30 +++
 rtl/fibo_bcd_display.sv | 108 ++++++++++
 tb/tb_fibo_bcd_display.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fibo_pkg.sv
// Shared types and constants for the Fibonacci BCD display stage.
// Holds the FSM encoding, datapath widths, segment glyphs and the add-3 adjust helper.
package fibo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    localparam int BIN_W  = 16;
    localparam int DIGITS = 5;
    localparam int BCD_W  = 20;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/fibo_bcd_display_seven_seg.sv
// Combinational BCD digit to active-low seven-segment glyph; blank or
// out-of-range nibbles turn every segment off.
module seven_seg_decoder
    import fibo_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_digit)
                4'd0:    o_seg = SEG_DIGIT[0];
                4'd1:    o_seg = SEG_DIGIT[1];
                4'd2:    o_seg = SEG_DIGIT[2];
                4'd3:    o_seg = SEG_DIGIT[3];
                4'd4:    o_seg = SEG_DIGIT[4];
                4'd5:    o_seg = SEG_DIGIT[5];
                4'd6:    o_seg = SEG_DIGIT[6];
                4'd7:    o_seg = SEG_DIGIT[7];
                4'd8:    o_seg = SEG_DIGIT[8];
                4'd9:    o_seg = SEG_DIGIT[9];
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/fibo_bcd_display.sv
// Converts a 16-bit binary value to 5 BCD digits by double-dabble (16 shift cycles)
// and drives five active-low seven-segment displays; start is dropped while busy.
module fibo_bcd_display
    import fibo_pkg::*;
#(
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [BIN_W-1:0]  value,
    output logic              busy,
    output logic              valid,
    output logic [BCD_W-1:0]  bcd_out,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1,
    output logic [6:0]        hex2,
    output logic [6:0]        hex3,
    output logic [6:0]        hex4
);

    fsm_t               r_state;
    fsm_t               w_next_state;
    logic [BIN_W-1:0]   r_bin_sh;
    logic [BCD_W-1:0]   r_bcd_sh;
    logic [4:0]         r_cnt;
    logic [BCD_W-1:0]   r_bcd_out;
    logic [BCD_W-1:0]   w_bcd_adj;
    logic [DIGITS-1:0]  w_blank;
    logic [6:0]         w_seg [DIGITS];

    assign w_bcd_adj = bcd_adjust(r_bcd_sh);

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = SHIFT;
            SHIFT:   if (r_cnt == 5'd1) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // DONE lasts exactly one cycle, so it doubles as the valid pulse.
    always_comb begin
        busy  = (r_state != IDLE);
        valid = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin_sh  <= '0;
            r_bcd_sh  <= '0;
            r_cnt     <= '0;
            r_bcd_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bin_sh <= value;
                        r_bcd_sh <= '0;
                        r_cnt    <= 5'd16;
                    end
                end
                SHIFT: begin
                    r_bcd_sh <= {w_bcd_adj[BCD_W-2:0], r_bin_sh[BIN_W-1]};
                    r_bin_sh <= {r_bin_sh[BIN_W-2:0], 1'b0};
                    r_cnt    <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1)
                        r_bcd_out <= {w_bcd_adj[BCD_W-2:0], r_bin_sh[BIN_W-1]};
                end
                default: ;
            endcase
        end
    end

    assign bcd_out = r_bcd_out;

    // A digit blanks only if it and every more-significant digit are zero.
    always_comb begin
        w_blank = '0;
        w_blank[DIGITS-1] = BLANK_LEADING && (r_bcd_out[4*(DIGITS-1) +: 4] == 4'd0);
        for (int k = DIGITS-2; k >= 1; k--)
            w_blank[k] = w_blank[k+1] && (r_bcd_out[4*k +: 4] == 4'd0);
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seven_seg_decoder u_dec (
            .i_digit (r_bcd_out[4*g +: 4]),
            .i_blank (w_blank[g]),
            .o_seg   (w_seg[g])
        );
    end

    assign hex0 = w_seg[0];
    assign hex1 = w_seg[1];
    assign hex2 = w_seg[2];
    assign hex3 = w_seg[3];
    assign hex4 = w_seg[4];

endmodule

// File: tb/tb_fibo_bcd_display.sv
// Self-checking bench: vector table, random values against a decimal model, and
// hand sequences for busy-drop and mid-conversion reset.
module tb_fibo_bcd_display;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] value = '0;
    logic        busy, valid;
    logic [19:0] bcd_out;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [6:0] GLYPH [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef struct {
        int          val;
        logic [19:0] exp_bcd;
    } vec_t;

    vec_t vecs [10];

    fibo_bcd_display #(.BLANK_LEADING(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .value(value),
        .busy(busy), .valid(valid), .bcd_out(bcd_out),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    function automatic int pow10(input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [19:0] model_bcd(input int v);
        logic [19:0] r = '0;
        for (int k = 0; k < 5; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
        return r;
    endfunction

    function automatic logic [6:0] model_hex(input int v, input int k);
        if (k > 0 && v < pow10(k)) return 7'h7F;
        return GLYPH[(v / pow10(k)) % 10];
    endfunction

    task automatic check_display(input string tag, input int v);
        chk({tag, " bcd_out"}, 32'(bcd_out), 32'(model_bcd(v)));
        chk({tag, " hex0"}, 32'(hex0), 32'(model_hex(v, 0)));
        chk({tag, " hex1"}, 32'(hex1), 32'(model_hex(v, 1)));
        chk({tag, " hex2"}, 32'(hex2), 32'(model_hex(v, 2)));
        chk({tag, " hex3"}, 32'(hex3), 32'(model_hex(v, 3)));
        chk({tag, " hex4"}, 32'(hex4), 32'(model_hex(v, 4)));
    endtask

    // Pulses start for one edge (E0) and follows the conversion until busy drops.
    task automatic run_conv(input int v, output int lat, output int busycnt, output int nvalid);
        @(negedge clk);
        start = 1'b1;
        value = 16'(v);
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; busycnt = 0; nvalid = 0;
        for (int n = 1; n <= 40; n++) begin
            if (busy) busycnt++;
            @(posedge clk); #1;
            if (valid) begin
                nvalid++;
                if (lat < 0) lat = n;
            end
            if (!busy) break;
        end
    endtask

    initial begin
        int lat, bc, nv, v;

        vecs[0] = '{6765,  20'h06765};
        vecs[1] = '{65535, 20'h65535};
        vecs[2] = '{0,     20'h00000};
        vecs[3] = '{10,    20'h00010};
        vecs[4] = '{1,     20'h00001};
        vecs[5] = '{55,    20'h00055};
        vecs[6] = '{46368, 20'h46368};
        vecs[7] = '{9,     20'h00009};
        vecs[8] = '{100,   20'h00100};
        vecs[9] = '{10000, 20'h10000};

        // Reset held two cycles
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset busy", 32'(busy), 0);
        chk("reset valid", 32'(valid), 0);
        chk("reset bcd_out", 32'(bcd_out), 0);
        chk("reset hex0", 32'(hex0), 32'(7'b1000000));
        chk("reset hex1", 32'(hex1), 32'h7F);
        chk("reset hex2", 32'(hex2), 32'h7F);
        chk("reset hex3", 32'(hex3), 32'h7F);
        chk("reset hex4", 32'(hex4), 32'h7F);

        for (int i = 0; i < 10; i++) begin
            run_conv(vecs[i].val, lat, bc, nv);
            chk("vec latency", 32'(lat), 16);
            chk("vec busy cycles", 32'(bc), 17);
            chk("vec valid count", 32'(nv), 1);
            chk("vec bcd table", 32'(bcd_out), 32'(vecs[i].exp_bcd));
            check_display("vec", vecs[i].val);
        end

        for (int i = 0; i < 20; i++) begin
            v = int'($urandom_range(0, 65535));
            run_conv(v, lat, bc, nv);
            chk("rand latency", 32'(lat), 16);
            check_display("rand", v);
        end

        // Busy drop: extra starts at E5 and E17 are ignored, E18 is accepted
        @(negedge clk);
        start = 1'b1; value = 16'd100;
        @(posedge clk); #1;
        start = 1'b0;
        nv = 0;
        for (int n = 1; n <= 17; n++) begin
            start = (n == 5 || n == 17);
            value = 16'd999;
            @(posedge clk); #1;
            start = 1'b0;
            if (valid) nv++;
        end
        chk("drop valid count", 32'(nv), 1);
        chk("drop bcd_out", 32'(bcd_out), 32'h00100);
        chk("drop idle after E17", 32'(busy), 0);
        start = 1'b1; value = 16'd999;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (valid) begin lat = n; break; end
        end
        chk("E18 accept latency", 32'(lat), 16);
        chk("E18 bcd_out", 32'(bcd_out), 32'h00999);
        @(posedge clk); #1;

        // Reset during SHIFT discards the conversion
        @(negedge clk);
        start = 1'b1; value = 16'd4181;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midreset busy", 32'(busy), 0);
        chk("midreset bcd_out", 32'(bcd_out), 0);
        nv = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (valid) nv++;
        end
        chk("midreset no valid", 32'(nv), 0);
        chk("midreset bcd held", 32'(bcd_out), 0);
        chk("midreset hex1 blank", 32'(hex1), 32'h7F);
        run_conv(4181, lat, bc, nv);
        chk("post reset latency", 32'(lat), 16);
        check_display("post reset", 4181);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
